branch_resolve_ctrl: RTL

- Sequences the branch comparator in the 5-stage RV32I pipeline.
- In IF: provides a taken/not-taken prediction from a pattern history table (PHT) of 2-bit saturating counters.
- In EX: consumes the comparator's br_en, detects mispredictions, issues a redirect PC and a multi-cycle flush of the younger stages, and trains the PHT.

---
 rtl/branch_resolve_ctrl_if.sv | 36 +++
 rtl/branch_resolve_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl_if.sv
// Bundle between the IF/EX pipeline stages and branch_resolve_ctrl.
// The pipeline uses the master modport and the controller uses the slave modport.
interface branch_resolve_ctrl_if;
    logic        if_valid;
    logic        if_is_br;
    logic [31:0] if_pc;
    logic        pred_taken;

    logic        ex_valid;
    logic        ex_is_br;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic        ex_br_en;
    logic [31:0] ex_target;
    logic        stall;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] perf_br_total;
    logic [31:0] perf_br_mispred;

    modport master (
        output if_valid, if_is_br, if_pc,
        output ex_valid, ex_is_br, ex_pc, ex_pred_taken, ex_br_en, ex_target, stall,
        input  pred_taken, redirect_valid, redirect_pc, flush,
        input  perf_br_total, perf_br_mispred
    );

    modport slave (
        input  if_valid, if_is_br, if_pc,
        input  ex_valid, ex_is_br, ex_pc, ex_pred_taken, ex_br_en, ex_target, stall,
        output pred_taken, redirect_valid, redirect_pc, flush,
        output perf_br_total, perf_br_mispred
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch prediction (2-bit PHT) in IF and resolution/redirect/flush sequencing in EX.
// Optional branch performance counters are enabled with BRANCH_PERF_CNT_EN.
module branch_resolve_ctrl #(
    parameter int unsigned IDX_BITS     = 6,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input logic                  clk,
    input logic                  rst,
    branch_resolve_ctrl_if.slave bus
);
    localparam int unsigned PHT_SIZE = 1 << IDX_BITS;
    localparam int unsigned CNT_W    = 3;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [1:0]          pht [PHT_SIZE];
    logic [IDX_BITS-1:0] if_idx;
    logic [IDX_BITS-1:0] ex_idx;

    logic [0:0]       state;
    logic [0:0]       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             flush_q;
    logic             flush_nx;
    logic             redirect_valid_q;
    logic             redirect_valid_nx;
    logic [31:0]      redirect_pc_q;
    logic [31:0]      redirect_pc_nx;

    logic resolve;
    logic mispredict;
    logic unused_if_pc_bits;

    assign if_idx = bus.if_pc[IDX_BITS+1:2];
    assign ex_idx = bus.ex_pc[IDX_BITS+1:2];
    assign unused_if_pc_bits = ^{bus.if_pc[31:IDX_BITS+2], bus.if_pc[1:0]};

    // Reads the pre-update table; a same-cycle training write shows up next cycle.
    assign bus.pred_taken = bus.if_valid & bus.if_is_br & pht[if_idx][1];

    assign resolve    = bus.ex_valid & bus.ex_is_br & ~bus.stall & (state == IDLE);
    assign mispredict = resolve & (bus.ex_br_en != bus.ex_pred_taken);

    // PHT training: saturating 2-bit counters
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < PHT_SIZE; i++) begin
                pht[i] <= 2'b01;
            end
        end else if (resolve) begin
            if (bus.ex_br_en) begin
                if (pht[ex_idx] != 2'b11) pht[ex_idx] <= pht[ex_idx] + 2'd1;
            end else begin
                if (pht[ex_idx] != 2'b00) pht[ex_idx] <= pht[ex_idx] - 2'd1;
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nx          = state;
        cnt_nx            = cnt;
        flush_nx          = flush_q;
        redirect_valid_nx = 1'b0;
        redirect_pc_nx    = redirect_pc_q;
        case (state)
            IDLE: begin
                if (mispredict) begin
                    state_nx          = FLUSH;
                    cnt_nx            = CNT_W'(FLUSH_CYCLES - 1);
                    flush_nx          = 1'b1;
                    redirect_valid_nx = 1'b1;
                    redirect_pc_nx    = bus.ex_br_en ? bus.ex_target : bus.ex_pc + 32'd4;
                end
            end
            FLUSH: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                    flush_nx = 1'b0;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                flush_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state            <= state_nx;
            cnt              <= cnt_nx;
            flush_q          <= flush_nx;
            redirect_valid_q <= redirect_valid_nx;
            redirect_pc_q    <= redirect_pc_nx;
        end
    end

    assign bus.flush          = flush_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] br_total_q;
    logic [31:0] br_mispred_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_total_q   <= '0;
            br_mispred_q <= '0;
        end else begin
            if (resolve)    br_total_q   <= br_total_q + 32'd1;
            if (mispredict) br_mispred_q <= br_mispred_q + 32'd1;
        end
    end

    assign bus.perf_br_total   = br_total_q;
    assign bus.perf_br_mispred = br_mispred_q;
`else
    assign bus.perf_br_total   = '0;
    assign bus.perf_br_mispred = '0;
`endif
endmodule
